// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: 16 sets x 32-byte lines, 32-bit CPU words.
// Optional statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_count_o,
    output logic [31:0]  miss_count_o
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   valid_q, valid_d;
    logic [15:0]   dirty_q, dirty_d;
    logic [26:0]   miss_line_q, miss_line_d;

    logic [22:0]   tag_mem  [16];
    logic [255:0]  line_mem [16];

    logic          req;
    logic          hit;
    logic [22:0]   cpu_tag;
    logic [3:0]    cpu_idx;
    logic [2:0]    cpu_word;
    logic [3:0]    miss_idx;
    logic [255:0]  cur_line;
    logic          fill_en;
    logic          wr_word_en;
    logic          unused_addr;

    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign cpu_tag     = cpu_addr_i[31:9];
    assign cpu_idx     = cpu_addr_i[8:5];
    assign cpu_word    = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];
    assign miss_idx    = miss_line_q[3:0];
    assign cur_line    = line_mem[cpu_idx];
    assign hit         = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign mem_data_o  = line_mem[miss_idx];

    // Array writes are gated by reset so an abandoned refill never lands.
    assign fill_en    = rst_i && (state_q == ALLOCATE) && mem_ack_i;
    assign wr_word_en = rst_i && (state_q == IDLE) && req && hit && cpu_MemWrite_i;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        miss_line_d  = miss_line_q;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (cpu_MemWrite_i) dirty_d[cpu_idx] = 1'b1;
                        else                cpu_data_o = cur_line[{cpu_word, 5'b0} +: 32];
                    end else begin
                        cpu_stall_o = 1'b1;
                        miss_line_d = {cpu_tag, cpu_idx};
                        state_d     = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_mem[miss_idx], miss_idx, 5'b0};
                if (mem_ack_i) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_line_q, 5'b0};
                if (mem_ack_i) begin
                    valid_d[miss_idx] = 1'b1;
                    dirty_d[miss_idx] = 1'b0;
                    state_d           = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                cpu_stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_line_q <= miss_line_d;
        end
    end

    // Data and tag arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            line_mem[miss_idx] <= mem_data_i;
            tag_mem[miss_idx]  <= miss_line_q[26:4];
        end else if (wr_word_en) begin
            line_mem[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && req) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller against a word-level memory model
// plus a residency table; a latency-randomizing memory responder serves misses.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what every word should read as, and which line each set holds.
    bit [31:0]  ref_mem   [bit [29:0]];
    bit [255:0] mem_store [bit [26:0]];
    bit         m_valid [16];
    bit         m_dirty [16];
    bit [22:0]  m_tag   [16];
    int         exp_hits = 0;
    int         exp_miss = 0;
    bit [32:0]  exp_txn [$];

    int force_lat = 0;
    bit resp_en   = 1'b1;
    bit inj_ack   = 1'b0;
    int lat_sum   = 0;

    function automatic bit [31:0] pat(bit [26:0] la, int w);
        return ({5'd0, la} * 32'h9E37_79B1) ^ (32'(w + 1) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic bit [255:0] mem_line(bit [26:0] la);
        bit [255:0] l;
        if (mem_store.exists(la)) return mem_store[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(la, w);
        return l;
    endfunction

    function automatic bit [31:0] ref_word(bit [29:0] wa);
        bit [255:0] l;
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = mem_line(wa[29:3]);
        return l[{wa[2:0], 5'b0} +: 32];
    endfunction

    function automatic bit [255:0] ref_line(bit [26:0] la);
        bit [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word({la, 3'(w)});
        return l;
    endfunction

    function automatic bit [31:0] exp_hit_cnt();
`ifdef DCACHE_STATS_EN
        return 32'(exp_hits);
`else
        return 32'd0;
`endif
    endfunction

    function automatic bit [31:0] exp_miss_cnt();
`ifdef DCACHE_STATS_EN
        return 32'(exp_miss);
`else
        return 32'd0;
`endif
    endfunction

    // Memory responder: checks each request against the expected transaction
    // list, holds it for a chosen latency, then pulses ack.
    initial begin
        bit        busy = 1'b0;
        int        cnt = 0;
        int        lat = 0;
        bit [31:0] a = '0;
        bit        w = 1'b0;
        bit [32:0] e;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = inj_ack;
            if (resp_en && mem_enable_o) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    a    = mem_addr_o;
                    w    = mem_write_o;
                    lat  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 5));
                    chk("txn_expected", 256'(exp_txn.size() != 0), 256'(1));
                    if (exp_txn.size() != 0) begin
                        e = exp_txn.pop_front();
                        chk("txn_write", 256'(w), 256'(e[32]));
                        chk("txn_addr", 256'(a), 256'(e[31:0]));
                        if (w) chk("wb_data", mem_data_o, ref_line(a[31:5]));
                    end
                end else begin
                    chk("hold_addr", 256'(mem_addr_o), 256'(a));
                    chk("hold_write", 256'(mem_write_o), 256'(w));
                end
                cnt++;
                if (cnt == lat) begin
                    mem_ack_i = 1'b1;
                    if (w) mem_store[a[31:5]] = mem_data_o;
                    else   mem_data_i = mem_line(a[31:5]);
                    lat_sum += lat;
                    busy = 1'b0;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input bit [31:0] addr,
                          input bit [31:0] wdata, output bit [31:0] rdata);
        bit [3:0]  idx = addr[8:5];
        bit [22:0] tg  = addr[31:9];
        bit [29:0] wa  = addr[31:2];
        bit        phit = m_valid[idx] && (m_tag[idx] == tg);
        int        stalls = 0;
        bit        served = 1'b0;
        rdata   = '0;
        lat_sum = 0;
        if (!phit) begin
            if (m_valid[idx] && m_dirty[idx]) exp_txn.push_back({1'b1, m_tag[idx], idx, 5'b0});
            exp_txn.push_back({1'b0, tg, idx, 5'b0});
            exp_miss++;
        end
        exp_hits++;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        for (int c = 0; c < 300 && !served; c++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                served = 1'b1;
                rdata  = cpu_data_o;
            end else begin
                stalls++;
                @(posedge clk_i); #1;
            end
        end
        chk("served", 256'(served), 256'(1));
        chk("stall_cycles", 256'(stalls), 256'(phit ? 0 : lat_sum + 2));
        if (!wr) chk("rdata", 256'(rdata), 256'(ref_word(wa)));
        if (!phit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_mem[wa]  = wdata;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk_i); #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        ref_mem.delete();
        exp_txn.delete();
        exp_hits = 0;
        exp_miss = 0;
    endtask

    initial begin
        bit [31:0]  r;
        bit [255:0] l;
        model_reset();
        l = mem_line(27'd2);
        l[95:64] = 32'hDEAD_BEEF;
        mem_store[27'd2] = l;

        repeat (3) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
        chk("rst_rdata", 256'(cpu_data_o), 256'(0));
        chk("rst_hits", 256'(hit_count_o), 256'(0));
        chk("rst_miss", 256'(miss_count_o), 256'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Cold miss fill, then hits on the resident line
        access(1'b1, 1'b0, 32'h0000_0048, 32'h0, r);
        chk("fill_word2", 256'(r), 256'(32'hDEAD_BEEF));
        access(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, r);
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, r);
        chk("write_readback", 256'(r), 256'(32'h1234_5678));
        access(1'b1, 1'b0, 32'h0000_0048, 32'h0, r);
        chk("stat_hits", 256'(hit_count_o), 256'(exp_hit_cnt()));
        chk("stat_miss", 256'(miss_count_o), 256'(exp_miss_cnt()));

        // Dirty victim at index 2 written back before the new fill
        access(1'b1, 1'b0, 32'h0000_0240, 32'h0, r);
        chk("wb_stored", 256'(mem_store[27'd2][63:32]), 256'(32'h1234_5678));

        // Long memory latency
        force_lat = 10;
        access(1'b1, 1'b0, 32'h0000_0AA0, 32'h0, r);
        force_lat = 0;

        // Idle cycles: no output, no state change
        for (int i = 0; i < 5; i++) begin
            cpu_addr_i = $urandom;
            cpu_data_i = $urandom;
            @(negedge clk_i);
            chk("idle_rdata", 256'(cpu_data_o), 256'(0));
            chk("idle_stall", 256'(cpu_stall_o), 256'(0));
            @(posedge clk_i); #1;
        end
        chk("idle_hits", 256'(hit_count_o), 256'(exp_hit_cnt()));

        // Reset in ALLOCATE, then a stray ack
        resp_en        = 1'b0;
        cpu_addr_i     = 32'h0000_1000;
        cpu_MemRead_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("alloc_en", 256'(mem_enable_o), 256'(1));
        chk("alloc_wr", 256'(mem_write_o), 256'(0));
        chk("alloc_addr", 256'(mem_addr_o), 256'(32'h0000_1000));
        chk("alloc_stall", 256'(cpu_stall_o), 256'(1));
        @(posedge clk_i); #1;
        rst_i         = 1'b0;
        cpu_MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i   = 1'b1;
        inj_ack = 1'b1;
        @(posedge clk_i); #1;
        inj_ack = 1'b0;
        model_reset();
        @(negedge clk_i);
        chk("abort_mem_en", 256'(mem_enable_o), 256'(0));
        chk("abort_stall", 256'(cpu_stall_o), 256'(0));
        chk("abort_miss", 256'(miss_count_o), 256'(0));
        @(posedge clk_i); #1;
        resp_en = 1'b1;
        access(1'b1, 1'b0, 32'h0000_1000, 32'h0, r);

        // Random mix over a few tags and sets to provoke conflicts
        for (int n = 0; n < 150; n++) begin
            bit [31:0] a;
            int        op;
            a  = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 5)), 3'($urandom), 2'($urandom)};
            op = int'($urandom_range(0, 3));
            access(op < 2, op >= 2, a, $urandom, r);
        end
        chk("end_hits", 256'(hit_count_o), 256'(exp_hit_cnt()));
        chk("end_miss", 256'(miss_count_o), 256'(exp_miss_cnt()));
        chk("end_txn_drained", 256'(exp_txn.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have no parameters; geometry is fixed: direct-mapped, 16 sets, 32-byte lines, 32-bit word access.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-low reset.
REQ-005 cpu_MemRead_i  input  1  MEM-stage load request.
REQ-006 cpu_MemWrite_i  input  1  MEM-stage store request.
REQ-007 cpu_addr_i  input  32  byte address: tag [31:9], index [8:5], word [4:2], [1:0] ignored.
REQ-008 cpu_data_i  input  32  store data.
REQ-009 cpu_data_o  output  32  load data, valid when the request is served.
REQ-010 cpu_stall_o  output  1  freezes all pipeline registers while high.
REQ-011 mem_enable_o  output  1  memory request, held until ack.
REQ-012 mem_write_o  output  1  1 = line write-back, 0 = line fetch.
REQ-013 mem_addr_o  output  32  line address, bits [4:0] = 0.
REQ-014 mem_data_o  output  256  write-back line data.
REQ-015 mem_data_i  input  256  fetched line, sampled in the ack cycle.
REQ-016 mem_ack_i  input  1  one-cycle completion pulse.
REQ-017 hit_count_o, miss_count_o  output  32 each  access statistics.

Function
REQ-018 request = cpu_MemRead_i | cpu_MemWrite_i; both high SHALL be treated as a write.
REQ-019 hit = valid[index] & (tag[index] == cpu_addr_i[31:9]).
REQ-020 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, and REFILL_DONE.
REQ-021 IDLE, request & hit: stall low; a read drives the selected word combinationally on cpu_data_o; a write updates the word at the edge and sets dirty; stay in IDLE.
REQ-022 IDLE, request & miss: stall high; go to WRITEBACK if the victim is valid & dirty, else to ALLOCATE.
REQ-023 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; on mem_ack_i go to ALLOCATE.
REQ-024 ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i store mem_data_i, set valid=1, dirty=0, tag=cpu tag, and go to REFILL_DONE.
REQ-025 REFILL_DONE: stall high, no memory request; always go to IDLE, where the access then hits (REQ-021).
REQ-026 cpu_stall_o SHALL be high in every non-IDLE state, and in IDLE exactly when request & ~hit.
REQ-027 mem_enable_o SHALL be low in IDLE and REFILL_DONE; mem_addr_o, mem_write_o, and mem_data_o SHALL be stable while mem_enable_o is high.
REQ-028 Miss latency with a clean victim SHALL be (memory latency + 2) stall cycles; with a dirty victim, both memory latencies + 2.
REQ-029 No cache state SHALL change when request is low.
REQ-030 When request is low, cpu_data_o SHALL be 0.

Reset
REQ-031 With rst_i low at an edge: state=IDLE; all valid and dirty bits=0; counters=0; mem_enable_o=0 from the next cycle.
REQ-032 Line data and tag arrays SHALL NOT be reset.
REQ-033 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction; a late mem_ack_i after reset SHALL be ignored.

Configuration
REQ-034 Macro DCACHE_STATS_EN defined: hit_count_o increments on each served access (IDLE & request & hit), and miss_count_o increments on each IDLE-to-WRITEBACK/ALLOCATE transition; both wrap at 2^32.
REQ-035 Macro DCACHE_STATS_EN undefined: no counter logic; hit_count_o and miss_count_o are tied to 0.

Verification
REQ-036 After reset, read 0x0000_0040 -> stall high; ALLOCATE addr 0x0000_0040; ack with line word2=0xDEAD_BEEF, read 0x48 afterwards -> 0xDEAD_BEEF with stall low.
REQ-037 Write 0x1234_5678 to 0x44 on a resident line -> no stall; then read 0x44 -> 0x1234_5678; line marked dirty.
REQ-038 With dirty line at index 2 (tag 0), read 0x0000_0240 -> WRITEBACK addr 0x0000_0040 with written data, then ALLOCATE addr 0x0000_0240.
REQ-039 Memory ack delayed 10 cycles -> mem_enable_o and mem_addr_o held stable, cpu_stall_o high through REFILL_DONE.
REQ-040 Assert rst_i low in ALLOCATE, then pulse mem_ack_i -> state IDLE, line stays invalid, next read misses.
REQ-041 With DCACHE_STATS_EN: 1 miss + 3 hits -> miss_count_o=1, hit_count_o=4 (the miss replay counts as a hit); without the macro, both read 0.
